// File: rtl/mvm_sched_pkg.sv
// Shared types and the round-robin pick helper for the MVM job scheduler.
package mvm_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    START   = 3'd2,
    FEED    = 3'd3,
    WAIT    = 3'd4,
    DRAIN   = 3'd5
  } sched_state_t;

  // First asserted request strictly after 'last', wrapping modulo n (n <= 32).
  function automatic logic rr_pick(input logic [31:0] req, input int n, input int last,
                                   output int idx);
    logic found;
    int   j;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= 32; k++) begin
      j = (last + k) % n;
      if (k <= n && !found && req[j[4:0]]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/mvm_rr_arbiter.sv
// Round-robin grant selection; holds the last-served client so the next
// search starts just after it.
module mvm_rr_arbiter
  import mvm_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  input  logic [ID_W-1:0]    adv_id_i,
  output logic [ID_W-1:0]    grant_o,
  output logic               grant_valid_o
);

  logic [ID_W-1:0] last_grant_q;
  int              pick_idx;

  always_ff @(posedge clk) begin
    if (reset)          last_grant_q <= ID_W'(NUM_REQ - 1);
    else if (advance_i) last_grant_q <= adv_id_i;
  end

  always_comb begin
    pick_idx      = 0;
    grant_valid_o = rr_pick(32'(req_i), NUM_REQ, int'(last_grant_q), pick_idx);
    grant_o       = ID_W'(pick_idx);
  end

endmodule

// File: rtl/mvm_job_scheduler.sv
// Buffers one job from the round-robin winner, streams it gaplessly into the
// shared MVM engine and returns the results tagged with the client id.
// Optional stall timeout with err pulse: define MVM_SCHED_TIMEOUT_EN.
module mvm_job_scheduler
  import mvm_sched_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int MAT_SCALE    = 4,
  parameter  int INPUT_WIDTH  = 8,
  parameter  int OUTPUT_WIDTH = 16,
  parameter  int OUT_LAT      = 1,
  parameter  int TIMEOUT      = 64,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           eng_start,
  output logic [INPUT_WIDTH-1:0]         eng_data_in,
  input  logic                           eng_done,
  input  logic [OUTPUT_WIDTH-1:0]        eng_data_out,
  output logic                           res_valid,
  output logic [OUTPUT_WIDTH-1:0]        res_data,
  output logic [ID_W-1:0]                res_id,
  output logic                           res_last,
`ifdef MVM_SCHED_TIMEOUT_EN
  output logic                           err,
`endif
  output logic                           busy
);

  localparam int JOB_WORDS = MAT_SCALE * MAT_SCALE + MAT_SCALE;
  localparam int CNT_W     = $clog2(JOB_WORDS + 1);
  localparam int DRN_W     = $clog2(OUT_LAT + MAT_SCALE + 1);

  sched_state_t            state_q, state_d;
  logic [ID_W-1:0]         owner_q, owner_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DRN_W-1:0]        drn_q, drn_d;
  logic [INPUT_WIDTH-1:0]  mem_q [JOB_WORDS];
  logic                    res_valid_q, res_last_q;
  logic [OUTPUT_WIDTH-1:0] res_data_q;
  logic [ID_W-1:0]         res_id_q;
  logic [ID_W-1:0]         grant;
  logic                    grant_valid, accept, capture, last_cap, advance, drop;

  assign accept   = (state_q == COLLECT) && req_valid[owner_q];
  // y[i] sits on the engine bus during DRAIN cycle OUT_LAT-1+i.
  assign capture  = (state_q == DRAIN) && (drn_q >= DRN_W'(OUT_LAT - 1));
  assign last_cap = capture && (drn_q == DRN_W'(OUT_LAT + MAT_SCALE - 2));
  assign advance  = last_cap || drop;

  mvm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk          (clk),
    .reset        (reset),
    .req_i        (req_valid),
    .advance_i    (advance),
    .adv_id_i     (owner_q),
    .grant_o      (grant),
    .grant_valid_o(grant_valid)
  );

`ifdef MVM_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             err_q, stall;

  assign stall = ((state_q == COLLECT) && !accept) || ((state_q == WAIT) && !eng_done);
  assign drop  = stall && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign err   = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= drop;
      tmo_q <= (stall && !drop) ? tmo_q + 1'b1 : '0;
    end
  end
`else
  assign drop = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    case (state_q)
      IDLE: if (grant_valid) begin
        owner_d = grant;
        cnt_d   = '0;
        state_d = COLLECT;
      end
      COLLECT: if (accept) begin
        if (cnt_q == CNT_W'(JOB_WORDS - 1)) begin
          cnt_d   = '0;
          state_d = START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = FEED;
      end
      FEED: begin
        if (cnt_q == CNT_W'(JOB_WORDS - 1)) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: if (eng_done) begin
        drn_d   = '0;
        state_d = DRAIN;
      end
      DRAIN: begin
        drn_d = drn_q + 1'b1;
        if (last_cap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (drop) begin
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      cnt_q       <= '0;
      drn_q       <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      drn_q       <= drn_d;
      res_valid_q <= capture;
      res_last_q  <= last_cap;
      if (capture) begin
        res_data_q <= eng_data_out;
        res_id_q   <= owner_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[cnt_q] <= req_data[owner_q*INPUT_WIDTH +: INPUT_WIDTH];
  end

  always_comb begin
    req_ready = '0;
    if (state_q == COLLECT) req_ready[owner_q] = 1'b1;
  end

  assign eng_data_in = (state_q == FEED) ? mem_q[cnt_q] : '0;
  assign eng_start   = (state_q == START);
  assign busy        = (state_q != IDLE);
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_id      = res_id_q;
  assign res_last    = res_last_q;

endmodule

// File: tb/tb_mvm_job_scheduler.sv
// Directed bench for mvm_job_scheduler: instance A with OUT_LAT=1, instance B
// with OUT_LAT=3; the bench drives the engine side itself.
module tb_mvm_job_scheduler;

  localparam int JW = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid    [2];
  logic [31:0] req_data     [2];
  logic        eng_done     [2];
  logic [15:0] eng_data_out [2];

  logic [3:0]  req_ready_a, req_ready_b;
  logic        eng_start_a, eng_start_b;
  logic [7:0]  eng_data_in_a, eng_data_in_b;
  logic        res_valid_a, res_valid_b, res_last_a, res_last_b, busy_a, busy_b;
  logic [15:0] res_data_a, res_data_b;
  logic [1:0]  res_id_a, res_id_b;
`ifdef MVM_SCHED_TIMEOUT_EN
  logic        err_a, err_b;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mvm_job_scheduler #(.NUM_REQ(4), .MAT_SCALE(4), .INPUT_WIDTH(8), .OUTPUT_WIDTH(16),
                      .OUT_LAT(1), .TIMEOUT(8)) u_dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_data(req_data[0]),
    .req_ready(req_ready_a), .eng_start(eng_start_a), .eng_data_in(eng_data_in_a),
    .eng_done(eng_done[0]), .eng_data_out(eng_data_out[0]), .res_valid(res_valid_a),
    .res_data(res_data_a), .res_id(res_id_a), .res_last(res_last_a),
`ifdef MVM_SCHED_TIMEOUT_EN
    .err(err_a),
`endif
    .busy(busy_a));

  mvm_job_scheduler #(.NUM_REQ(4), .MAT_SCALE(4), .INPUT_WIDTH(8), .OUTPUT_WIDTH(16),
                      .OUT_LAT(3), .TIMEOUT(8)) u_dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_data(req_data[1]),
    .req_ready(req_ready_b), .eng_start(eng_start_b), .eng_data_in(eng_data_in_b),
    .eng_done(eng_done[1]), .eng_data_out(eng_data_out[1]), .res_valid(res_valid_b),
    .res_data(res_data_b), .res_id(res_id_b), .res_last(res_last_b),
`ifdef MVM_SCHED_TIMEOUT_EN
    .err(err_b),
`endif
    .busy(busy_b));

  function automatic logic [3:0]  rdy(input int s);   return (s != 0) ? req_ready_b   : req_ready_a;   endfunction
  function automatic logic        start(input int s); return (s != 0) ? eng_start_b   : eng_start_a;   endfunction
  function automatic logic [7:0]  din(input int s);   return (s != 0) ? eng_data_in_b : eng_data_in_a; endfunction
  function automatic logic        rv(input int s);    return (s != 0) ? res_valid_b   : res_valid_a;   endfunction
  function automatic logic [15:0] rd(input int s);    return (s != 0) ? res_data_b    : res_data_a;    endfunction
  function automatic logic [1:0]  rid(input int s);   return (s != 0) ? res_id_b      : res_id_a;      endfunction
  function automatic logic        rl(input int s);    return (s != 0) ? res_last_b    : res_last_a;    endfunction
  function automatic logic        bsy(input int s);   return (s != 0) ? busy_b        : busy_a;        endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    eng_done[0] = 1'b0;
    eng_done[1] = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Streams nw words base..base+nw-1 from client c; owner goes quiet for
  // gap_len cycles once gap_after words have been taken.
  task automatic send_job(input int s, input int c, input int base, input int nw,
                          input int gap_after, input int gap_len, input bit keep);
    logic [3:0] r;
    bit         acc;
    for (int w = 0; w < nw; w++) begin
      if (w == gap_after) begin
        req_valid[s][c] = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          tick();
          chk("gap_ready", 32'(rdy(s)), 32'(1) << c);
        end
      end
      req_valid[s][c] = 1'b1;
      req_data[s][c*8 +: 8] = 8'(base + w);
      acc = 1'b0;
      for (int t = 0; t < 40 && !acc; t++) begin
        r = rdy(s);
        if (r != 4'b0) chk("ready_onehot", 32'(r), 32'(1) << c);
        acc = r[c];
        tick();
      end
      chk("word_accepted", 32'(acc), 1);
    end
    if (!keep) req_valid[s][c] = 1'b0;
  endtask

  task automatic feed(input int s, input int base, input int done_k, input int reset_k);
    chk("eng_start", 32'(start(s)), 1);
    tick();
    for (int k = 0; k < JW; k++) begin
      if (k == reset_k) begin
        eng_done[s] = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("busy_after_reset", 32'(bsy(s)), 0);
        chk("start_after_reset", 32'(start(s)), 0);
        return;
      end
      chk("feed_word", 32'(din(s)), 32'(8'(base + k)));
      chk("start_low_feed", 32'(start(s)), 0);
      eng_done[s] = (k == done_k);
      tick();
    end
    eng_done[s] = 1'b0;
    chk("din_zero_wait", 32'(din(s)), 0);
    chk("busy_wait", 32'(bsy(s)), 1);
  endtask

  // Engine stub: y[i] on the bus at done+olat+i; result expected one cycle later.
  task automatic respond(input int s, input int c, input int olat, input logic [15:0] y0,
                         input logic [15:0] y1, input logic [15:0] y2, input logic [15:0] y3,
                         input bit chk_idle);
    logic [15:0] y [4];
    int          i;
    bit          ev;
    y[0] = y0; y[1] = y1; y[2] = y2; y[3] = y3;
    eng_done[s] = 1'b1;
    tick();
    eng_done[s] = 1'b0;
    for (int cyc = 1; cyc <= olat + 4; cyc++) begin
      i = cyc - olat;
      if (i >= 0 && i < 4) eng_data_out[s] = y[i];
      else                 eng_data_out[s] = 16'hBEEF;
      i  = cyc - olat - 1;
      ev = (i >= 0 && i < 4);
      chk("res_valid", 32'(rv(s)), 32'(ev));
      if (ev) begin
        chk("res_data", 32'(rd(s)), 32'(y[i]));
        chk("res_id", 32'(rid(s)), c);
        chk("res_last", 32'(rl(s)), 32'(i == 3));
      end
      tick();
    end
    eng_data_out[s] = 16'h0;
    chk("res_valid_end", 32'(rv(s)), 0);
    if (chk_idle) chk("idle_after_drain", 32'(bsy(s)), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = '0;
      req_data[s] = '0;
      eng_done[s] = 1'b0;
      eng_data_out[s] = '0;
    end
    reset = 1'b1;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      chk("rst_busy", 32'(bsy(s)), 0);
      chk("rst_res_valid", 32'(rv(s)), 0);
      chk("rst_eng_start", 32'(start(s)), 0);
      chk("rst_req_ready", 32'(rdy(s)), 0);
      chk("rst_eng_data_in", 32'(din(s)), 0);
      chk("rst_res_data", 32'(rd(s)), 0);
      chk("rst_res_id", 32'(rid(s)), 0);
      chk("rst_res_last", 32'(rl(s)), 0);
    end
    reset = 1'b0;

    // single job from client 2
    send_job(0, 2, 1, JW, -1, 0, 1'b0);
    feed(0, 1, -1, -1);
    respond(0, 2, 1, 16'd100, 16'd200, 16'd300, 16'd400, 1'b1);

    // all clients pending: grant order 0,1,2,3,0
    do_reset();
    req_valid[0] = 4'hF;
    for (int j = 0; j < 5; j++) begin
      send_job(0, j % 4, 20 * j + 1, JW, -1, 0, 1'b1);
      if (j == 4) req_valid[0] = 4'h0;
      feed(0, 20 * j + 1, -1, -1);
      respond(0, j % 4, 1, 16'(1000 * j + 1), 16'(1000 * j + 2), 16'(1000 * j + 3),
              16'(1000 * j + 4), j == 4);
    end

    // owner gap after word 7, signed extremes on the result path
    send_job(0, 1, 40, JW, 7, 5, 1'b0);
    feed(0, 40, -1, -1);
    respond(0, 1, 1, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 1'b1);

    // reset in FEED word 10: job dropped, priority back to client 0
    send_job(0, 2, 60, JW, -1, 0, 1'b0);
    feed(0, 60, -1, 10);
    for (int t = 0; t < 6; t++) begin
      eng_done[0] = (t == 2);
      chk("no_res_after_reset", 32'(rv(0)), 0);
      chk("idle_after_reset", 32'(bsy(0)), 0);
      tick();
    end
    eng_done[0] = 1'b0;
    req_valid[0] = 4'b0101;
    tick();
    chk("grant_after_reset", 32'(rdy(0)), 32'h1);
    send_job(0, 0, 80, JW, -1, 0, 1'b0);
    req_valid[0][2] = 1'b0;
    feed(0, 80, -1, -1);
    respond(0, 0, 1, 16'd7, 16'd8, 16'd9, 16'd10, 1'b1);

    // eng_done during FEED is ignored
    send_job(0, 3, 5, JW, -1, 0, 1'b0);
    feed(0, 5, 6, -1);
    respond(0, 3, 1, 16'd11, 16'd22, 16'd33, 16'd44, 1'b1);

    // OUT_LAT=3 instance
    send_job(1, 1, 100, JW, -1, 0, 1'b0);
    feed(1, 100, 12, -1);
    respond(1, 1, 3, 16'h1234, 16'h8765, 16'h00FF, 16'hFF00, 1'b1);

`ifdef MVM_SCHED_TIMEOUT_EN
    // client 0 stalls after 3 words while client 1 waits
    do_reset();
    req_valid[0] = 4'b0011;
    send_job(0, 0, 1, 3, -1, 0, 1'b0);
    for (int t = 0; t < 8; t++) begin
      chk("err_low_stall", 32'(err_a), 0);
      tick();
    end
    chk("err_pulse", 32'(err_a), 1);
    chk("idle_after_timeout", 32'(busy_a), 0);
    tick();
    chk("err_one_cycle", 32'(err_a), 0);
    chk("grant_after_timeout", 32'(rdy(0)), 32'h2);
    req_valid[0] = 4'b0000;
    do_reset();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
